// File: rtl/logic_op_arb_pkg.sv
// ----------------------------------------------------------------------------
// logic_op_arb_pkg
// Shared definitions for the logic-op arbiter:
//   - opcode constants for the 2-input bitwise logic unit
//   - FSM state encoding used by logic_op_arbiter
// ----------------------------------------------------------------------------
package logic_op_arb_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op_arb_pick.sv
// ----------------------------------------------------------------------------
// logic_op_arb_pick
// Combinational rotate-priority picker. Requester `ptr` has the highest
// priority, then ptr+1, ... wrapping modulo N_REQ. Tying ptr to zero gives
// plain lowest-index-wins fixed priority.
// Ports:
//   req   [N_REQ-1:0] : request vector
//   ptr   [IDW-1:0]   : index of the highest-priority requester
//   grant [N_REQ-1:0] : one-hot grant (all zero when no request)
//   idx   [IDW-1:0]   : index of the granted requester (0 when none)
//   any               : at least one request present
// ----------------------------------------------------------------------------
module logic_op_arb_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    // Walk the requesters in priority order; the first one found wins.
    always_comb begin
        int  j;
        logic sel;
        j     = 0;
        sel   = 1'b0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j        = (int'(ptr) + k) % N_REQ;
            sel      = ~any & req[j];
            grant[j] = sel;
            idx      = sel ? IDW'(j) : idx;
            any      = any | sel;
        end
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// logic_op_arbiter
// Shares one registered bitwise logic unit (AND/OR/XOR/NAND) between N_REQ
// requesters (N_REQ >= 2). A request is accepted in IDLE, executed in EXEC and
// held as a tagged response in RESP until the consumer takes it. One
// transaction is in flight at a time, so the minimum initiation interval is
// three cycles.
// Parameters: N_REQ (requesters), W (operand/result width).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/op/a/b           : per-requester request, slice i for requester i
//   req_ready [N_REQ-1:0]      : one-hot accept strobe, only high in IDLE
//   rsp_valid/rsp_id/rsp_data  : registered response, rsp_ready consumes it
//   busy                       : registered, high whenever not in IDLE
// Build option:
//   LOGIC_OP_ARB_FIXED_PRIO_EN : lowest-index requester always wins and the
//                                round-robin pointer is removed.
// ----------------------------------------------------------------------------
module logic_op_arbiter
    import logic_op_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [W*N_REQ-1:0]       req_a,
    input  logic [W*N_REQ-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   pick_idx_s;
    logic             pick_any_s;
    logic [IDW-1:0]   pick_ptr_s;
    logic             accept_s;

    function automatic logic [W-1:0] logic_op(input logic [1:0]   op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef LOGIC_OP_ARB_FIXED_PRIO_EN
    assign pick_ptr_s = '0;
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    assign pick_ptr_s = ptr_q;

    // Next pointer: one past the winner, wrapping at N_REQ-1.
    always_comb begin
        if (accept_s) begin
            ptr_d = (pick_idx_s == IDW'(N_REQ - 1)) ? '0 : pick_idx_s + IDW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    logic_op_arb_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (pick_ptr_s),
        .grant (grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    assign accept_s  = (state_q == ST_IDLE) & pick_any_s;
    assign req_ready = (state_q == ST_IDLE) ? grant_s : '0;

    // FSM next state, operand capture and result computation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d  = ST_EXEC;
                    op_d     = req_op[2*int'(pick_idx_s) +: 2];
                    a_d      = req_a[W*int'(pick_idx_s) +: W];
                    b_d      = req_b[W*int'(pick_idx_s) +: W];
                    rsp_id_d = pick_idx_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d = logic_op(op_q, a_q, b_q);
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                // rsp_valid is always high here, so rsp_ready alone completes.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_op_arbiter
// Directed bench for logic_op_arbiter (N_REQ=4, W=8). Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_logic_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_ready;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    logic_op_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[id]      = 1'b1;
        req_op[2*id +: 2]  = op;
        req_a[W*id +: W]   = a;
        req_b[W*id +: W]   = b;
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Single transaction from one requester, response taken immediately.
    task automatic do_txn(input string nm, input int id, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(id, op, a, b);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({nm, " req_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check({nm, " exec busy"}, 32'(busy), 32'd1);
        check({nm, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, " rsp_id"}, 32'(rsp_id), 32'(id));
        check({nm, " rsp_data"}, 32'(rsp_data), 32'(exp));
    endtask

    initial begin
        int got[5];
        int exp_rr[5];
        int n;
        int seen;

        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        vecs[0] = '{2, 2'b00, 8'hF0, 8'h3C, 8'h30};
        vecs[1] = '{0, 2'b00, 8'hAA, 8'h0F, 8'h0A};
        vecs[2] = '{0, 2'b01, 8'hAA, 8'h0F, 8'hAF};
        vecs[3] = '{0, 2'b10, 8'hAA, 8'h0F, 8'hA5};
        vecs[4] = '{0, 2'b11, 8'hAA, 8'h0F, 8'hF5};
        vecs[5] = '{1, 2'b11, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{3, 2'b10, 8'hFF, 8'h00, 8'hFF};
`ifdef LOGIC_OP_ARB_FIXED_PRIO_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif

        // Reset values
        #12;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven opcode vectors
        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Round-robin from a fresh pointer with all requesters valid
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 8'(i), 8'h10);
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check($sformatf("rr onehot %0d", n), 32'($countones(req_ready)), 32'd1);
                got[n] = oh2idx(req_ready);
                n++;
            end
        end
        check("rr grant count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("rr grant %0d", i), 32'(got[i]), 32'(exp_rr[i]));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Wrap: only req 3, then req 0 and req 3 together
        do_txn("wrap3", 3, 2'b00, 8'hFF, 8'h81, 8'h81);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(0, 2'b01, 8'h01, 8'h02);
        set_req(3, 2'b01, 8'h04, 8'h08);
        @(negedge clk);
        check("wrap0 req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("wrap0 rsp_id", 32'(rsp_id), 32'd0);
        check("wrap0 rsp_data", 32'(rsp_data), 32'h03);

        // Backpressure: response held for five cycles
        @(posedge clk); #1;
        req_valid = '0;
        set_req(1, 2'b10, 8'h55, 8'hFF);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp accept", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(0, 2'b00, 8'hFF, 8'h0F);
        @(negedge clk);
        check("bp exec req_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_id", c), 32'(rsp_id), 32'd1);
            check($sformatf("bp%0d rsp_data", c), 32'(rsp_data), 32'hAA);
            check($sformatf("bp%0d busy", c), 32'(busy), 32'd1);
            check($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release still resp", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("bp idle busy", 32'(busy), 32'd0);
        check("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp next grant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp next rsp_id", 32'(rsp_id), 32'd0);
        check("bp next rsp_data", 32'(rsp_data), 32'h0F);

        // Reset in the middle of EXEC
        @(posedge clk); #1;
        req_valid = '0;
        set_req(2, 2'b01, 8'h12, 8'h21);
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-rst req_ready", 32'(req_ready), 32'd0);
        check("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid-rst rsp_id", 32'(rsp_id), 32'd0);
        check("mid-rst rsp_data", 32'(rsp_data), 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid-rst no response", 32'(seen), 32'd0);
        @(posedge clk); #1;
        set_req(1, 2'b11, 8'hFF, 8'h0F);
        set_req(3, 2'b00, 8'hFF, 8'hFF);
        @(negedge clk);
        check("post-rst grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("post-rst rsp_id", 32'(rsp_id), 32'd1);
        check("post-rst rsp_data", 32'(rsp_data), 32'hF0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
